// File: rtl/mips_multicycle_core_if.sv
// rtl/mips_multicycle_core_if.sv - instruction and data memory req/ack bus
interface mips_multicycle_core_if #(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 16,
  parameter int DADDR_W = 16
) ();

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [15:0]        imem_rdata;

  logic               dmem_req;
  logic               dmem_we;
  logic [DADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic               dmem_ack;
  logic [DATA_W-1:0]  dmem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multi-cycle 16-bit-ISA MIPS core with req/ack memory ports
module mips_multicycle_core #(
  parameter int              DATA_W   = 16,
  parameter int              PC_W     = 16,
  parameter int              DADDR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mips_multicycle_core_if.master bus,
  output logic [PC_W-1:0]        pc,
  output logic                   halted,
  output logic                   retire,
  output logic [DATA_W-1:0]      dbg_a,
  output logic [DATA_W-1:0]      dbg_b,
  output logic [DATA_W-1:0]      dbg_alu
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BNE  = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hB;

  typedef enum logic [2:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [15:0]       ir;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] st_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] mdr_q;
  logic [DATA_W-1:0] regs [16];

  logic [3:0]        op;
  logic [3:0]        ra;
  logic [3:0]        rb;
  logic [3:0]        rc;
  logic [DATA_W-1:0] imm_data;
  logic [PC_W-1:0]   imm_pc;
  logic              use_imm;
  logic              is_rtype;
  logic              is_ctrl;
  logic              br_taken;
  logic [3:0]        wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] alu_res;

  assign op       = ir[15:12];
  assign ra       = ir[11:8];
  assign rb       = ir[7:4];
  assign rc       = ir[3:0];
  assign imm_data = {{(DATA_W-4){ir[3]}}, ir[3:0]};
  assign imm_pc   = {{(PC_W-4){ir[3]}}, ir[3:0]};
  assign use_imm  = (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  assign is_rtype = (op <= OP_SLT);
  // Instructions that finish in EXEC: branches, jump and the NOP range
  assign is_ctrl  = (op >= OP_BNE) && (op != OP_HALT);
  assign br_taken = ((op == OP_BNE) && (a_q != b_q)) || ((op == OP_BEQ) && (a_q == b_q));
  assign wb_dest  = is_rtype ? rc : rb;
  assign wb_data  = (op == OP_LW) ? mdr_q : alu_q;

  // Bus outputs decode straight from the state register so req cannot pulse outside FETCH/MEM
  assign bus.imem_req   = (state == S_FETCH);
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = (state == S_MEM);
  assign bus.dmem_we    = (state == S_MEM) && (op == OP_SW);
  assign bus.dmem_addr  = alu_q[DADDR_W-1:0];
  assign bus.dmem_wdata = st_q;

  assign dbg_a   = a_q;
  assign dbg_b   = b_q;
  assign dbg_alu = alu_q;

  // ALU on the operands latched in DECODE; address ops reuse the adder
  always_comb begin
    alu_res = a_q + b_q;
    case (op)
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_SLT:  alu_res = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1) : '0;
      default: alu_res = a_q + b_q;
    endcase
  end

  // Control FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RST;
    else        state <= state_next;
  end

  // Control FSM next-state; FETCH and MEM hold until their ack
  always_comb begin
    state_next = state;
    case (state)
      S_RST:    state_next = S_FETCH;
      S_FETCH:  if (bus.imem_ack) state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        if (is_rtype || (op == OP_ADDI))          state_next = S_WB;
        else if ((op == OP_LW) || (op == OP_SW))  state_next = S_MEM;
        else if (op == OP_HALT)                   state_next = S_HALT;
        else                                      state_next = S_FETCH;
      end
      S_MEM: begin
        if (bus.dmem_ack) state_next = (op == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_RST;
    endcase
  end

  // Datapath registers: IR/PC on fetch, operands on decode, ALU and branch on exec, load data on mem
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      ir     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      st_q   <= '0;
      alu_q  <= '0;
      mdr_q  <= '0;
      halted <= 1'b0;
      retire <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          if (bus.imem_ack) begin
            ir <= bus.imem_rdata;
            pc <= pc + PC_W'(1);
          end
        end
        S_DECODE: begin
          a_q  <= regs[ra];
          st_q <= regs[rb];
          b_q  <= use_imm ? imm_data : regs[rb];
        end
        S_EXEC: begin
          alu_q <= alu_res;
          // pc already points past this instruction, so branch targets add to it directly
          if (br_taken)           pc <= pc + imm_pc;
          else if (op == OP_JMP)  pc <= PC_W'(ir[11:0]);
          if (op == OP_HALT)      halted <= 1'b1;
          if (is_ctrl)            retire <= 1'b1;
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            if (op == OP_LW) mdr_q  <= bus.dmem_rdata;
            else             retire <= 1'b1;
          end
        end
        S_WB: begin
          retire <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Register file: R0 is never written, so it always reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if ((state == S_WB) && (wb_dest != 4'd0)) begin
      regs[wb_dest] <= wb_data;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb/tb_mips_multicycle_core.sv - scoreboard bench with ISA reference model
module tb_mips_multicycle_core;

  localparam int              DW  = 32;
  localparam int              PW  = 12;
  localparam int              AW  = 16;
  localparam logic [PW-1:0]   RPC = 12'h010;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] pc;
  logic          halted;
  logic          retire;
  logic [DW-1:0] dbg_a;
  logic [DW-1:0] dbg_b;
  logic [DW-1:0] dbg_alu;

  mips_multicycle_core_if #(.DATA_W(DW), .PC_W(PW), .DADDR_W(AW)) bus ();

  mips_multicycle_core #(.DATA_W(DW), .PC_W(PW), .DADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .pc(pc), .halted(halted),
    .retire(retire), .dbg_a(dbg_a), .dbg_b(dbg_b), .dbg_alu(dbg_alu)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    op;
    logic [PW-1:0] npc;
    logic [DW-1:0] alu;
    int            lat;
  } ret_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_t;

  logic [15:0]   imem     [4096];
  logic [DW-1:0] dmem     [65536];
  logic [DW-1:0] ref_dmem [65536];
  ret_t          ret_q [$];
  mem_t          mem_q [$];

  logic [DW-1:0] mr [16];
  logic [PW-1:0] mpc;
  bit            m_halt;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int i_lo = 0, i_hi = 0, d_lo = 0, d_hi = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int r = 0; r < 16; r++) mr[r] = '0;
    mpc    = RPC;
    m_halt = 1'b0;
  endtask

  // Instruction-level reference: executes n instructions, queuing what each retire and memory access must show
  task automatic model_run(input int n);
    for (int k = 0; k < n && !m_halt; k++) begin
      logic [15:0]   ins;
      logic [3:0]    op, ra, rb, rc;
      int            simm;
      logic [DW-1:0] a, b, res;
      logic [PW-1:0] npc;
      ret_t          e;
      mem_t          m;
      ins  = imem[mpc];
      op   = ins[15:12];
      ra   = ins[11:8];
      rb   = ins[7:4];
      rc   = ins[3:0];
      simm = (rc >= 4'd8) ? int'(rc) - 16 : int'(rc);
      a    = mr[ra];
      b    = mr[rb];
      res  = a + DW'(simm);
      npc  = mpc + PW'(1);
      case (op)
        4'h0: begin res = a + b; mr[rc] = res; end
        4'h1: begin res = a - b; mr[rc] = res; end
        4'h2: begin res = a & b; mr[rc] = res; end
        4'h3: begin res = a | b; mr[rc] = res; end
        4'h4: begin res = ($signed(a) < $signed(b)) ? DW'(1) : '0; mr[rc] = res; end
        4'h5: mr[rb] = res;
        4'h6: begin
          m.we = 1'b0; m.addr = res[AW-1:0]; m.wdata = '0;
          mem_q.push_back(m);
          mr[rb] = ref_dmem[m.addr];
        end
        4'h7: begin
          m.we = 1'b1; m.addr = res[AW-1:0]; m.wdata = b;
          mem_q.push_back(m);
          ref_dmem[m.addr] = b;
        end
        4'h8: if (a != b) npc = npc + PW'(simm);
        4'h9: if (a == b) npc = npc + PW'(simm);
        4'hA: npc = PW'(ins[11:0]);
        4'hB: m_halt = 1'b1;
        default: ;
      endcase
      mr[0] = '0;
      if (!m_halt) begin
        e.op  = op;
        e.npc = npc;
        e.alu = res;
        e.lat = (op <= 4'h5) ? 4 : (op == 4'h6) ? 5 : (op == 4'h7) ? 4 : 3;
        ret_q.push_back(e);
      end
      mpc = npc;
    end
  endtask

  // Memory responder: random or fixed wait states, junk acks while idle, data-access checks
  bit i_busy = 0, d_busy = 0;
  int i_cnt = 0, i_w = 0, d_cnt = 0, d_w = 0;
  initial begin
    mem_t m;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.imem_req) begin
        if (!i_busy) begin i_busy = 1; i_cnt = 0; i_w = $urandom_range(i_hi, i_lo); end
        if (i_cnt == i_w) begin
          bus.imem_ack = 1'b1; bus.imem_rdata = imem[bus.imem_addr]; i_busy = 0;
        end else begin
          bus.imem_ack = 1'b0; bus.imem_rdata = 16'($urandom); i_cnt++;
        end
      end else begin
        i_busy = 0; bus.imem_ack = 1'($urandom); bus.imem_rdata = 16'($urandom);
      end
      if (bus.dmem_req) begin
        if (!d_busy) begin d_busy = 1; d_cnt = 0; d_w = $urandom_range(d_hi, d_lo); end
        if (d_cnt == d_w) begin
          bus.dmem_ack = 1'b1; d_busy = 0;
          if (mem_q.size() == 0) chk("mem_unexpected", 64'(1), 64'(0));
          else begin
            m = mem_q.pop_front();
            chk("mem_we", 64'(bus.dmem_we), 64'(m.we));
            chk("mem_addr", 64'(bus.dmem_addr), 64'(m.addr));
            if (m.we) chk("mem_wdata", 64'(bus.dmem_wdata), 64'(m.wdata));
          end
          if (bus.dmem_we) dmem[bus.dmem_addr] = bus.dmem_wdata;
          else             bus.dmem_rdata = dmem[bus.dmem_addr];
        end else begin
          bus.dmem_ack = 1'b0; bus.dmem_rdata = $urandom; d_cnt++;
        end
      end else begin
        d_busy = 0; bus.dmem_ack = 1'($urandom); bus.dmem_rdata = $urandom;
      end
    end
  end

  // Retire monitor: pops the scoreboard, checks next pc, ALU result and latency including observed waits
  int cnt = 0, waits = 0;
  bit halt_seen = 0;
  ret_t e_mon;
  always @(negedge clk) begin
    if (!rst_n) begin
      cnt = 0; waits = 0; halt_seen = 0;
    end else begin
      if (halted && !halt_seen) begin
        halt_seen = 1;
        chk("halt_expected", 64'(halted), 64'(m_halt));
        chk("halt_latency", 64'(cnt), 64'(3 + waits));
      end
      if (retire) begin
        if (ret_q.size() == 0) chk("retire_unexpected", 64'(1), 64'(0));
        else begin
          e_mon = ret_q.pop_front();
          chk("retire_pc", 64'(pc), 64'(e_mon.npc));
          if (e_mon.op < 4'h8) chk("retire_alu", 64'(dbg_alu), 64'(e_mon.alu));
          chk("retire_latency", 64'(cnt), 64'(e_mon.lat + waits));
        end
        cnt = 1; waits = 0;
      end else if (cnt > 0 || bus.imem_req) begin
        cnt++;
      end
      if (bus.imem_req && !bus.imem_ack) waits++;
      if (bus.dmem_req && !bus.dmem_ack) waits++;
    end
  end

  task automatic fill_nop();
    for (int a = 0; a < 4096; a++) imem[a] = 16'hC000;
  endtask

  task automatic finish_prog(input int max_cyc);
    int k = 0;
    while ((ret_q.size() != 0 || mem_q.size() != 0 || (m_halt && !halted)) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk("prog_complete", 64'(k < max_cyc), 64'(1));
    if (m_halt) begin
      repeat (6) @(negedge clk);
      chk("halt_pc", 64'(pc), 64'(mpc));
      chk("halt_imem_req", 64'(bus.imem_req), 64'(0));
      chk("halt_retire", 64'(retire), 64'(0));
    end
  endtask

  task automatic run_prog(input int n, input int max_cyc);
    rst_n = 1'b0;
    ret_q.delete(); mem_q.delete();
    model_reset();
    model_run(n);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    finish_prog(max_cyc);
  endtask

  initial begin
    int k;
    logic [3:0] rop;
    for (int a = 0; a < 65536; a++) begin
      dmem[a] = $urandom;
      ref_dmem[a] = dmem[a];
    end
    dmem[1] = 32'h7FFF_FFFF;
    ref_dmem[1] = 32'h7FFF_FFFF;

    // ALU chain, R0 writes, SW/LW with two wait states, then HALT
    fill_nop();
    imem[12'h010] = 16'h5017; imem[12'h011] = 16'h502D; imem[12'h012] = 16'h0123;
    imem[12'h013] = 16'h4214; imem[12'h014] = 16'h5101; imem[12'h015] = 16'h0005;
    imem[12'h016] = 16'h7032; imem[12'h017] = 16'h6052; imem[12'h018] = 16'h0506;
    imem[12'h019] = 16'hB000;
    i_lo = 0; i_hi = 0; d_lo = 2; d_hi = 2;
    rst_n = 1'b0;
    model_reset();
    model_run(20);
    repeat (3) @(negedge clk);
    chk("rst_pc", 64'(pc), 64'(12'h010));
    chk("rst_imem_req", 64'(bus.imem_req), 64'(0));
    chk("rst_dmem_req", 64'(bus.dmem_req), 64'(0));
    chk("rst_dmem_we", 64'(bus.dmem_we), 64'(0));
    chk("rst_halted", 64'(halted), 64'(0));
    chk("rst_retire", 64'(retire), 64'(0));
    chk("rst_dbg", 64'(dbg_a | dbg_b | dbg_alu), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_fetch_req", 64'(bus.imem_req), 64'(1));
    chk("first_fetch_addr", 64'(bus.imem_addr), 64'(12'h010));
    finish_prog(500);

    // Branches: BEQ taken backwards, JMP to 0xFFF, BNE not taken wraps to 0x000, HALT there
    fill_nop();
    imem[12'h010] = 16'h5015; imem[12'h011] = 16'h5025; imem[12'h012] = 16'hA005;
    imem[12'h004] = 16'hAFFF; imem[12'h005] = 16'h912E; imem[12'hFFF] = 16'h8123;
    imem[12'h000] = 16'hB000;
    i_lo = 0; i_hi = 2; d_lo = 0; d_hi = 2;
    run_prog(20, 500);

    // HALT at 0x003, zero-wait
    fill_nop();
    imem[12'h010] = 16'hA000; imem[12'h003] = 16'hB000;
    i_lo = 0; i_hi = 0;
    run_prog(20, 300);
    chk("halt_pc_frozen", 64'(pc), 64'(12'h004));

    // Signed overflow wraps modulo 2^32
    fill_nop();
    imem[12'h010] = 16'h6011; imem[12'h011] = 16'h5021; imem[12'h012] = 16'h0123;
    imem[12'h013] = 16'hB000;
    i_lo = 0; i_hi = 1; d_lo = 0; d_hi = 1;
    run_prog(20, 300);

    // Reset during a load's wait: request drops at once, no write, no retire
    fill_nop();
    imem[12'h010] = 16'h6073; imem[12'h011] = 16'hB000;
    i_lo = 0; i_hi = 0; d_lo = 5; d_hi = 5;
    rst_n = 1'b0;
    ret_q.delete(); mem_q.delete();
    model_reset();
    model_run(2);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (!bus.dmem_req && k < 100) begin @(negedge clk); k++; end
    chk("midreset_in_mem", 64'(bus.dmem_req), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("midreset_dmem_req", 64'(bus.dmem_req), 64'(0));
    chk("midreset_retire", 64'(retire), 64'(0));
    ret_q.delete(); mem_q.delete();
    @(negedge clk);
    imem[12'h010] = 16'h0701;
    run_prog(20, 300);

    // Random programs with random wait states on both ports
    for (int a = 0; a < 4096; a++) begin
      rop = 4'($urandom_range(15, 0));
      if (rop == 4'hB) rop = 4'hC;
      imem[a] = {rop, 12'($urandom)};
    end
    i_lo = 0; i_hi = 3; d_lo = 0; d_hi = 3;
    run_prog(300, 20000);
    rst_n = 1'b0;

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
